// File: rtl/seg_access_ctrl.sv
// -----------------------------------------------------------------------------
// seg_access_ctrl
//
// Shares the four-entry segment register file (CS=00, DS=01, SS=10, ES=11)
// between the prefetch unit and the execution unit (EU).
//
// A read access selects a segment and waits out the file's one-cycle
// registered read latency. It then forms the 20-bit physical address
// (segment << 4) + offset and offers it to the bus interface.
// A segment write is issued to the file directly and produces no address.
//
// Access sequence (one access in flight at a time):
//   read : IDLE (accept) -> SEL -> CAPT -> OUT (until addr_ready) -> IDLE
//   write: IDLE (accept) -> WRITE -> IDLE
//
// Handshakes:
//   fetch_req / eu_req are level requests held until the matching gnt.
//   Requests are only sampled in IDLE. Each gnt is a single-cycle pulse in
//   the cycle after the accepting edge. phys_addr / addr_src / addr_wrap
//   are held stable while addr_valid=1. The transfer happens on a rising
//   edge where addr_valid && addr_ready, and addr_valid drops on the next
//   cycle.
//
// Arbitration: the EU wins, unless fetch is pending and the EU has already
// been granted STARVE_LIMIT times in a row while fetch waited.
//
// Parameters:
//   STARVE_LIMIT  consecutive EU grants allowed while fetch waits (1..7)
//   FETCH_SEG     segment code used for fetch accesses
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fetch_req/offset/gnt      prefetch request, IP offset, grant pulse
//   eu_req/wr/seg/offset/     EU request: write flag, segment, offset,
//   eu_wdata/eu_gnt             write data, grant pulse
//   seg_write_en/reg_select/  segment file write enable, select, write data
//   seg_wdata
//   seg_rdata                 segment file registered read data
//   addr_valid/ready          physical address handshake
//   phys_addr/addr_src        physical address, source (0 fetch, 1 EU)
//   addr_wrap                 carry out of bit 19 (optional feature)
//   dbg_state_o               current FSM state, for debug and checkers
//
// Build option:
//   SEG_WRAP_CHK_EN  when defined, addr_wrap reports the carry out of bit 19
//                    of the address sum. Otherwise addr_wrap is tied to 0.
// -----------------------------------------------------------------------------
module seg_access_ctrl #(
  parameter int unsigned STARVE_LIMIT = 2,
  parameter logic [1:0]  FETCH_SEG    = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_offset,
  output logic        fetch_gnt,
  input  logic        eu_req,
  input  logic        eu_wr,
  input  logic [1:0]  eu_seg,
  input  logic [15:0] eu_offset,
  input  logic [15:0] eu_wdata,
  output logic        eu_gnt,
  output logic        seg_write_en,
  output logic [1:0]  seg_reg_select,
  output logic [15:0] seg_wdata,
  input  logic [15:0] seg_rdata,
  output logic        addr_valid,
  input  logic        addr_ready,
  output logic [19:0] phys_addr,
  output logic        addr_src,
  output logic        addr_wrap,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_SEL   = 3'd2,
    ST_CAPT  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        fetch_gnt_q, fetch_gnt_d;
  logic        eu_gnt_q, eu_gnt_d;
  logic        seg_we_q, seg_we_d;
  logic [1:0]  seg_sel_q, seg_sel_d;
  logic [15:0] seg_wdata_q, seg_wdata_d;
  logic        addr_valid_q, addr_valid_d;
  logic [19:0] phys_addr_q, phys_addr_d;
  logic        addr_src_q, addr_src_d;
  logic [15:0] off_q, off_d;   // offset captured at grant
  logic        src_q, src_d;   // requester captured at grant (1 = EU)

  logic        starved;
  logic        fetch_win;
  logic        eu_win;
  logic [19:0] addr_sum;

  // ---------------------------------------------------------------------------
  // Address adder. seg_rdata is only meaningful in CAPT, where it is consumed.
  // ---------------------------------------------------------------------------
`ifdef SEG_WRAP_CHK_EN
  logic [20:0] sum_full;
  logic        addr_wrap_q;

  assign sum_full = {1'b0, seg_rdata, 4'b0000} + {5'b00000, off_q};
  assign addr_sum = sum_full[19:0];

  // Carry of the 20-bit sum, captured alongside phys_addr and held with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_wrap_q <= 1'b0;
    end else if (state_q == ST_CAPT) begin
      addr_wrap_q <= sum_full[20];
    end
  end

  assign addr_wrap = addr_wrap_q;
`else
  assign addr_sum  = {seg_rdata, 4'b0000} + {4'b0000, off_q};
  assign addr_wrap = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration (only effective in IDLE)
  // ---------------------------------------------------------------------------
  assign starved   = fetch_req && (starve_q == LIMIT);
  assign eu_win    = (state_q == ST_IDLE) && eu_req && !starved;
  assign fetch_win = (state_q == ST_IDLE) && fetch_req && (!eu_req || starved);

  // Consecutive EU grants while fetch waits. Any cycle without a fetch
  // request restarts the count, so only an unbroken wait builds it up.
  always_comb begin
    starve_d = starve_q;
    if (!fetch_req || fetch_win) begin
      starve_d = 3'd0;
    end else if (eu_win && (starve_q != LIMIT)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_gnt_d  = 1'b0;
    eu_gnt_d     = 1'b0;
    seg_we_d     = 1'b0;
    seg_sel_d    = seg_sel_q;     // select holds outside SEL and WRITE
    seg_wdata_d  = seg_wdata_q;
    addr_valid_d = addr_valid_q;
    phys_addr_d  = phys_addr_q;
    addr_src_d   = addr_src_q;
    off_d        = off_q;
    src_d        = src_q;

    unique case (state_q)
      ST_IDLE: begin
        if (eu_win) begin
          eu_gnt_d  = 1'b1;
          src_d     = 1'b1;
          off_d     = eu_offset;
          seg_sel_d = eu_seg;
          if (eu_wr) begin
            // Write is presented to the file during the WRITE cycle and
            // lands on its closing edge, ahead of any later SEL.
            seg_we_d    = 1'b1;
            seg_wdata_d = eu_wdata;
            state_d     = ST_WRITE;
          end else begin
            state_d = ST_SEL;
          end
        end else if (fetch_win) begin
          fetch_gnt_d = 1'b1;
          src_d       = 1'b0;
          off_d       = fetch_offset;
          seg_sel_d   = FETCH_SEG;
          state_d     = ST_SEL;
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      // The file registers its output at the end of SEL, so the data is
      // usable one cycle later in CAPT.
      ST_SEL: begin
        state_d = ST_CAPT;
      end

      ST_CAPT: begin
        phys_addr_d  = addr_sum;
        addr_src_d   = src_q;
        addr_valid_d = 1'b1;
        state_d      = ST_OUT;
      end

      ST_OUT: begin
        if (addr_ready) begin
          addr_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_q     <= 3'd0;
      fetch_gnt_q  <= 1'b0;
      eu_gnt_q     <= 1'b0;
      seg_we_q     <= 1'b0;
      seg_sel_q    <= 2'b00;
      seg_wdata_q  <= 16'h0000;
      addr_valid_q <= 1'b0;
      phys_addr_q  <= 20'h00000;
      addr_src_q   <= 1'b0;
      off_q        <= 16'h0000;
      src_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      fetch_gnt_q  <= fetch_gnt_d;
      eu_gnt_q     <= eu_gnt_d;
      seg_we_q     <= seg_we_d;
      seg_sel_q    <= seg_sel_d;
      seg_wdata_q  <= seg_wdata_d;
      addr_valid_q <= addr_valid_d;
      phys_addr_q  <= phys_addr_d;
      addr_src_q   <= addr_src_d;
      off_q        <= off_d;
      src_q        <= src_d;
    end
  end

  assign fetch_gnt      = fetch_gnt_q;
  assign eu_gnt         = eu_gnt_q;
  assign seg_write_en   = seg_we_q;
  assign seg_reg_select = seg_sel_q;
  assign seg_wdata      = seg_wdata_q;
  assign addr_valid     = addr_valid_q;
  assign phys_addr      = phys_addr_q;
  assign addr_src       = addr_src_q;
  assign dbg_state_o    = state_q;

endmodule
